uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_frame_if.sv | 33 +++
 rtl/uart_tx_serializer.sv | 40 ++++
 rtl/uart_tx_frame.sv | 107 ++++++++++
 tb/tb_uart_tx_frame.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side byte request bundle plus the serial line and busy flag.
// Latency: n/a (wiring only).
// Backpressure: host must hold off while busy; requests during busy are dropped.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data,
    output data_valid,
    output par_en,
    output par_typ,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  p_data,
    input  data_valid,
    input  par_en,
    input  par_typ,
    output tx_out,
    output busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter holding the data bits of one frame.
// Latency: load takes effect on the next edge; one shift per enabled edge.
// Backpressure: none; the controlling FSM decides when to load and shift.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_cur_bit,
  output logic                  o_next_bit,
  output logic                  o_ser_done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;

  // Load clears the counter so it reads 0 on entry to DATA; shifting stops at the last bit, so it never wraps.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_cur_bit  = r_shift[0];
  assign o_next_bit = r_shift[1];
  assign o_ser_done = (r_cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, data LSB first, optional parity, stop bit.
// Latency: start bit appears the cycle after the accepting edge; one bit per clock.
// Backpressure: busy high for the whole frame; requests while busy are ignored.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_frame_if.slave  bus
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_tx;
  logic   w_tx_nxt;
  logic   r_busy;
  logic   w_busy_nxt;
  logic   r_par_en;
  logic   r_par;
  logic   w_load;
  logic   w_shift;
  logic   w_cur_bit;
  logic   w_next_bit;
  logic   w_ser_done;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (bus.p_data),
    .o_cur_bit  (w_cur_bit),
    .o_next_bit (w_next_bit),
    .o_ser_done (w_ser_done)
  );

  // State plus registered line/busy; parity options are captured only at the accepting edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      if (w_load) begin
        r_par_en <= bus.par_en;
        r_par    <= (^bus.p_data) ^ (bus.par_typ == PAR_ODD);
      end
    end
  end

  // Next state and the line value for the next cycle, so the outputs come straight from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    w_busy_nxt  = 1'b1;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        if (bus.data_valid) begin
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      START: begin
        w_state_nxt = DATA;
        w_tx_nxt    = w_cur_bit;
      end
      DATA: begin
        if (!w_ser_done) begin
          w_shift  = 1'b1;
          w_tx_nxt = w_next_bit;
        end else if (r_par_en) begin
          w_state_nxt = PARITY;
          w_tx_nxt    = r_par;
        end else begin
          w_state_nxt = STOP;
        end
      end
      PARITY: begin
        w_state_nxt = STOP;
      end
      STOP: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.tx_out = r_tx;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame against a bit-list frame model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_frame;
  import uart_pkg::*;

  typedef bit bitq_t[$];

  logic CLK = 1'b0;
  logic RST;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame_if #(.DATA_WIDTH(8)) bus();

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line values from the cycle after acceptance to the stop bit.
  function automatic bitq_t model_frame(input logic [7:0] d, input bit pe, input bit pt);
    bitq_t q;
    int    ones;
    q    = {};
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) q.push_back(bit'(ones % 2) ^ pt);
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check($sformatf("%s idle tx c%0d", tag, i), 32'(bus.tx_out), 32'd1);
      check($sformatf("%s idle busy c%0d", tag, i), 32'(bus.busy), 32'd0);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first idle cycle after the frame.
  task automatic do_frame(input logic [7:0] d, input bit pe, input bit pt,
                          input bit hold, input bit noise, input int pulse_at,
                          input string tag);
    bitq_t exp;
    exp = model_frame(d, pe, pt);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    for (int i = 0; i < exp.size(); i++) begin
      @(negedge CLK);
      if (!hold) bus.data_valid = 1'b0;
      check($sformatf("%s tx bit%0d", tag, i), 32'(bus.tx_out), 32'(exp[i]));
      check($sformatf("%s busy bit%0d", tag, i), 32'(bus.busy), 32'd1);
      if (noise) begin
        bus.p_data     = 8'($urandom);
        bus.par_en     = 1'($urandom);
        bus.par_typ    = 1'($urandom);
        bus.data_valid = 1'($urandom);
      end
      if (i == pulse_at) begin
        bus.p_data     = 8'h55;
        bus.par_en     = ~pe;
        bus.par_typ    = ~pt;
        bus.data_valid = 1'b1;
      end
    end
    @(negedge CLK);
    check($sformatf("%s gap tx", tag), 32'(bus.tx_out), 32'd1);
    check($sformatf("%s gap busy", tag), 32'(bus.busy), 32'd0);
    if (!hold) bus.data_valid = 1'b0;
  endtask

  initial begin
    RST            = 1'b1;
    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;

    // Reset held for two cycles, then idle with no requests.
    @(negedge CLK);
    check("reset tx c0", 32'(bus.tx_out), 32'd1);
    check("reset busy c0", 32'(bus.busy), 32'd0);
    @(negedge CLK);
    check("reset tx c1", 32'(bus.tx_out), 32'd1);
    check("reset busy c1", 32'(bus.busy), 32'd0);
    RST = 1'b0;
    idle_check(4, "post reset");

    // Directed frames: no parity, even parity, odd parity both ways.
    do_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, "A5 nopar");
    do_frame(8'h07, 1'b1, PAR_EVEN, 1'b0, 1'b0, -1, "07 even");
    idle_check(1, "after 07");
    do_frame(8'h03, 1'b1, PAR_ODD, 1'b0, 1'b0, -1, "03 odd");
    do_frame(8'h01, 1'b1, PAR_ODD, 1'b0, 1'b0, -1, "01 odd");

    // Request of 8'h55 with flipped options mid-frame must not disturb 8'hFF nor queue.
    do_frame(8'hFF, 1'b1, PAR_EVEN, 1'b0, 1'b0, 4, "FF busy");
    idle_check(4, "no queued frame");

    // Continuous valid: frames back to back with exactly one idle cycle.
    do_frame(8'h3C, 1'b0, PAR_EVEN, 1'b1, 1'b0, -1, "cont1");
    do_frame(8'hC3, 1'b1, PAR_ODD, 1'b1, 1'b0, -1, "cont2");
    do_frame(8'h96, 1'b1, PAR_EVEN, 1'b0, 1'b0, -1, "cont3");
    idle_check(2, "after cont");

    // Reset during d3, with a simultaneous request that must be ignored.
    bus.p_data     = 8'hC6;
    bus.par_en     = 1'b1;
    bus.par_typ    = PAR_EVEN;
    bus.data_valid = 1'b1;
    @(negedge CLK);
    bus.data_valid = 1'b0;
    check("midrst start", 32'(bus.tx_out), 32'd0);
    repeat (4) @(negedge CLK);
    check("midrst d3", 32'(bus.tx_out), 32'd0);
    check("midrst d3 busy", 32'(bus.busy), 32'd1);
    RST            = 1'b1;
    bus.data_valid = 1'b1;
    @(negedge CLK);
    check("midrst tx", 32'(bus.tx_out), 32'd1);
    check("midrst busy", 32'(bus.busy), 32'd0);
    RST            = 1'b0;
    bus.data_valid = 1'b0;
    idle_check(3, "after midrst");
    do_frame(8'h5A, 1'b1, PAR_ODD, 1'b0, 1'b0, -1, "post midrst");

    // Randomised frames with mid-frame input noise and random idle gaps.
    for (int k = 0; k < 20; k++) begin
      logic [7:0] d;
      bit         pe;
      bit         pt;
      int         gap;
      d   = 8'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      gap = int'($urandom_range(0, 3));
      do_frame(d, pe, pt, 1'b0, 1'b1, -1, $sformatf("rnd%0d", k));
      if (gap > 0) idle_check(gap, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
